// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width for a given operand width (WIDTH >= 2).
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Operand/result handshake bundle between a requester and serial_sub.
interface serial_sub_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             valid;

  modport master (
    output start, a, b, bin,
    input  ready, d, bout, valid
  );

  modport slave (
    input  start, a, b, bin,
    output ready, d, bout, valid
  );

endinterface

// File: rtl/serial_sub_fs.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module serial_sub_fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flop walk
// the operands LSB first, producing a - b - bin after WIDTH bit-steps.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  serial_sub_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state, state_nxt;
  logic               load, step, last;
  logic [WIDTH-1:0]   sa, sb, res;
  logic               br;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   d_q;
  logic               bout_q;
  logic               fs_d, fs_bout;
  logic [WIDTH-1:0]   res_nxt;

  // Single bit-step cell: current LSBs of the operands and the running borrow.
  serial_sub_fs u_fs (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .d    (fs_d),
    .bout (fs_bout)
  );

  assign last    = (cnt == CNT_W'(WIDTH - 1));
  assign res_nxt = {fs_d, res[WIDTH-1:1]};

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and load/step decode; start is only honoured in IDLE or DONE.
  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shift registers, borrow flop, counter and result registers.
  // NOTE: the shift registers are reset along with everything else so an
  // aborted operation leaves no stale bits and simulation starts defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
    end else if (load) begin
      sa  <= bus.a;
      sb  <= bus.b;
      br  <= bus.bin;
      cnt <= '0;
    end else if (step) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      br  <= fs_bout;
      res <= res_nxt;
      cnt <= cnt + CNT_W'(1);
      // Publish on the final step, including the bit computed this cycle.
      if (last) begin
        d_q    <= res_nxt;
        bout_q <= fs_bout;
      end
    end
  end

  assign bus.ready = (state == IDLE) || (state == DONE);
  assign bus.valid = (state == DONE);
  assign bus.d     = d_q;
  assign bus.bout  = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed and randomised self-check of serial_sub at WIDTH=8 and WIDTH=16.
module tb_serial_sub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(8))  bus8  ();
  serial_sub_if #(.WIDTH(16)) bus16 ();

  serial_sub #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  serial_sub #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One 8-bit operation: returns result, edges from accept to valid,
  // samples with ready low, and ready in the valid cycle.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      output logic [7:0] d, output logic bout,
                      output int lat, output int rdy_low, output logic rdy_v);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.bin = bin;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    lat = 0; rdy_low = 0; d = '0; bout = 1'b0; rdy_v = 1'b0;
    if (!bus8.ready) rdy_low++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus8.valid) begin
        lat = k; d = bus8.d; bout = bus8.bout; rdy_v = bus8.ready;
        break;
      end
      if (!bus8.ready) rdy_low++;
    end
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       output logic [15:0] d, output logic bout, output int lat);
    @(negedge clk);
    bus16.start = 1'b1; bus16.a = a; bus16.b = b; bus16.bin = bin;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    lat = 0; d = '0; bout = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (bus16.valid) begin
        lat = k; d = bus16.d; bout = bus16.bout;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       bin;
    logic [7:0] d;
    logic       bout;
  } vec_t;

  vec_t vecs[5] = '{
    '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0},
    '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1},
    '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0},
    '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1},
    '{8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0}
  };

  initial begin
    logic [7:0]  d8;
    logic [15:0] d16;
    logic        bo, rv;
    int          lat, rl;

    bus8.start  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.bin  = 1'b0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.bin = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus8.ready, 1'b1);
    check("rst_valid", bus8.valid, 1'b0);
    check("rst_d",     bus8.d,     8'h00);
    check("rst_bout",  bus8.bout,  1'b0);
    @(negedge clk) rst = 1'b0;

    // Directed vectors; the first also checks latency and ready timing.
    foreach (vecs[i]) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].bin, d8, bo, lat, rl, rv);
      check($sformatf("dir%0d_d", i),    d8, vecs[i].d);
      check($sformatf("dir%0d_bout", i), bo, vecs[i].bout);
      if (i == 0) begin
        check("lat8",         lat, 8);
        check("ready_low8",   rl,  8);
        check("ready_in_val", rv,  1'b1);
      end
    end
    @(posedge clk); #1;
    check("idle_after_done_valid", bus8.valid, 1'b0);

    // Back-to-back with start held; junk operands and a mid-RUN pulse ignored.
    begin
      int v1 = 0, v2 = 0, v3 = 0;
      logic [7:0] d1 = '0, d2 = '0;
      logic b1 = 1'b0, b2 = 1'b0;
      @(negedge clk);
      bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h01; bus8.bin = 1'b0;
      @(posedge clk); #1;
      bus8.a = 8'hAA; bus8.b = 8'h55; bus8.bin = 1'b1;
      for (int k = 1; k <= 26; k++) begin
        @(posedge clk); #1;
        if (bus8.valid) begin
          if (v1 == 0)      begin v1 = k; d1 = bus8.d; b1 = bus8.bout; end
          else if (v2 == 0) begin v2 = k; d2 = bus8.d; b2 = bus8.bout; end
          else              v3++;
        end
        if (k == 4)  begin bus8.a = 8'h01; bus8.b = 8'h02; bus8.bin = 1'b0; end
        if (k == 9)  bus8.start = 1'b0;
        if (k == 12) begin
          check("hold_d_in_run", bus8.d, 8'h0F);
          bus8.start = 1'b1; bus8.a = 8'h77; bus8.b = 8'h11;
        end
        if (k == 13) bus8.start = 1'b0;
      end
      check("b2b_v1_at", v1, 8);
      check("b2b_v2_at", v2, 17);
      check("b2b_d1", d1, 8'h0F);
      check("b2b_b1", b1, 1'b0);
      check("b2b_d2", d2, 8'hFF);
      check("b2b_b2", b2, 1'b1);
      check("b2b_no_extra", v3, 0);
    end

    // Asynchronous reset three cycles into RUN.
    begin
      int nv = 0;
      @(negedge clk);
      bus8.start = 1'b1; bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.bin = 1'b0;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_d", bus8.d, 8'hFF);
      #1 rst = 1'b1;
      #1;
      check("arst_ready", bus8.ready, 1'b1);
      check("arst_valid", bus8.valid, 1'b0);
      check("arst_d",     bus8.d,     8'h00);
      check("arst_bout",  bus8.bout,  1'b0);
      @(negedge clk) rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
        @(posedge clk); #1;
        if (bus8.valid) nv++;
      end
      check("arst_no_valid", nv, 0);
      run8(8'hC3, 8'h42, 1'b1, d8, bo, lat, rl, rv);
      check("post_rst_d",    d8, 8'h80);
      check("post_rst_bout", bo, 1'b0);
      check("post_rst_lat",  lat, 8);
    end

    // Randomised operations against an integer reference.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      int         diff;
      logic [7:0] ed;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom_range(0, 1));
      diff = int'(ra) - int'(rb) - int'(rc);
      ed = diff[7:0];
      run8(ra, rb, rc, d8, bo, lat, rl, rv);
      check($sformatf("rnd8_%0d", i), {bo, d8}, {(int'(ra) < int'(rb) + int'(rc)), ed});
      check($sformatf("rnd8_lat_%0d", i), lat, 8);
    end

    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      logic        rc;
      int          diff;
      logic [15:0] ed;
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
      diff = int'(ra) - int'(rb) - int'(rc);
      ed = diff[15:0];
      run16(ra, rb, rc, d16, bo, lat);
      check($sformatf("rnd16_%0d", i), {bo, d16}, {(int'(ra) < int'(rb) + int'(rc)), ed});
      check($sformatf("rnd16_lat_%0d", i), lat, 16);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
